sdram_rw_arbiter: RTL and testbench

- Shares one HPS SDRAM bidirectional Avalon-MM burst master port between two requesters: a video write channel (frame writer) and a video read channel (frame reader).
- Arbitration is round-robin at burst granularity.
- Enforces a cap on outstanding read beats and returns read data to the read channel.
- Sits between the frame-buffer DMA engines and the FPGA-to-HPS SDRAM bridge.

---
 rtl/sdram_rw_arbiter_if.sv | 41 ++++
 rtl/sdram_rw_arbiter.sv | 169 ++++++++++++++++
 tb/tb_sdram_rw_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_rw_arbiter_if.sv
// rtl/sdram_rw_arbiter_if.sv - Avalon-MM burst bus shared by the arbiter's requester and master ports
//
// One signal bundle serves all three arbiter ports; the modports pick the
// direction from the arbiter's point of view.
//   sdram_write_slave_port     : write requester (address, burstcount, writedata,
//                                byteenable, write in; waitrequest out)
//   sdram_read_slave_port      : read requester (address, burstcount, read in;
//                                waitrequest, readdata, readdatavalid out)
//   sdram_bidirect_master_port : shared SDRAM master (command out; waitrequest,
//                                readdata, readdatavalid in)
interface sdram_ifc #(
  parameter int WIDTH_ADDR = 29,
  parameter int WIDTH_DATA = 64,
  parameter int WIDTH_BE   = 8,
  parameter int WIDTH_BC   = 8
);
  logic [WIDTH_ADDR-1:0] address;
  logic [WIDTH_BC-1:0]   burstcount;
  logic [WIDTH_DATA-1:0] writedata;
  logic [WIDTH_BE-1:0]   byteenable;
  logic                  write;
  logic                  read;
  logic                  waitrequest;
  logic [WIDTH_DATA-1:0] readdata;
  logic                  readdatavalid;

  modport sdram_write_slave_port (
    input  address, burstcount, writedata, byteenable, write,
    output waitrequest
  );

  modport sdram_read_slave_port (
    input  address, burstcount, read,
    output waitrequest, readdata, readdatavalid
  );

  modport sdram_bidirect_master_port (
    output address, burstcount, writedata, byteenable, write, read,
    input  waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/sdram_rw_arbiter.sv
// rtl/sdram_rw_arbiter.sv - round-robin burst arbiter sharing one SDRAM master between a write and a read channel
//
// Ports:
//   clk, reset     : single clock, synchronous active-high reset
//   wr_s           : frame-writer burst write requester
//   rd_s           : frame-reader burst read requester
//   m              : shared Avalon-MM burst master towards the SDRAM bridge
//   rd_outstanding : read beats issued but not yet returned
//   busy           : FSM not idle or reads still outstanding
//   rdv_err        : sticky, readdatavalid arrived with nothing outstanding
module sdram_rw_arbiter #(
  parameter int WIDTH_ADDR   = 29,
  parameter int WIDTH_DATA   = 64,
  parameter int WIDTH_BE     = 8,
  parameter int MAX_RD_BEATS = 256
) (
  input  logic                             clk,
  input  logic                             reset,
  sdram_ifc.sdram_write_slave_port         wr_s,
  sdram_ifc.sdram_read_slave_port          rd_s,
  sdram_ifc.sdram_bidirect_master_port     m,
  output logic [8:0]                       rd_outstanding,
  output logic                             busy,
  output logic                             rdv_err
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_BURST = 2'd1,
    ST_RD_CMD   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_WRITE = 1'b0,
    GNT_READ  = 1'b1
  } grant_t;

  state_t      state_q, state_d;
  grant_t      last_grant_q, last_grant_d;
  logic [7:0]  wr_beats_q, wr_beats_d;
  logic [8:0]  rd_outstanding_q, rd_outstanding_d;
  logic        rdv_err_q, rdv_err_d;

  logic [7:0]  wr_bc_eff;
  logic [7:0]  rd_bc_eff;
  logic [9:0]  rd_sum;
  logic        wr_elig;
  logic        rd_elig;
  logic        wr_accept;
  logic        rd_accept;
  logic        rdv_stray;
  logic [9:0]  rd_next_wide;

  // A burstcount of 0 is treated as a single beat.
  assign wr_bc_eff = (wr_s.burstcount == 8'd0) ? 8'd1 : wr_s.burstcount;
  assign rd_bc_eff = (rd_s.burstcount == 8'd0) ? 8'd1 : rd_s.burstcount;

  // Widened to 10 bits so a near-full counter plus a long burst cannot wrap.
  assign rd_sum  = {1'b0, rd_outstanding_q} + {2'b00, rd_bc_eff};
  assign rd_elig = rd_s.read && (rd_sum <= 10'(MAX_RD_BEATS));
  assign wr_elig = wr_s.write;

  assign wr_accept = (state_q == ST_WR_BURST) && wr_s.write && !m.waitrequest;
  assign rd_accept = (state_q == ST_RD_CMD) && rd_s.read && !m.waitrequest;

  // A returning beat with nothing outstanding does not belong to any issued read.
  assign rdv_stray = m.readdatavalid && (rd_outstanding_q == 9'd0);

  // Command forwarding: the granted requester drives the master directly.
  always_comb begin
    m.address        = {WIDTH_ADDR{1'b0}};
    m.burstcount     = 8'd0;
    m.writedata      = {WIDTH_DATA{1'b0}};
    m.byteenable     = {WIDTH_BE{1'b0}};
    m.write          = 1'b0;
    m.read           = 1'b0;
    wr_s.waitrequest = 1'b1;
    rd_s.waitrequest = 1'b1;
    case (state_q)
      ST_WR_BURST: begin
        m.address        = wr_s.address;
        m.burstcount     = wr_s.burstcount;
        m.writedata      = wr_s.writedata;
        m.byteenable     = wr_s.byteenable;
        m.write          = wr_s.write;
        wr_s.waitrequest = m.waitrequest;
      end
      ST_RD_CMD: begin
        m.address        = rd_s.address;
        m.burstcount     = rd_s.burstcount;
        m.read           = rd_s.read;
        rd_s.waitrequest = m.waitrequest;
      end
      default: ;
    endcase
  end

  // Read data is returned unconditionally, independent of the grant.
  assign rd_s.readdata      = m.readdata;
  assign rd_s.readdatavalid = m.readdatavalid;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wr_beats_d   = wr_beats_q;
    rdv_err_d    = rdv_err_q | rdv_stray;

    case (state_q)
      ST_IDLE: begin
        if (wr_elig && (!rd_elig || last_grant_q == GNT_READ)) begin
          state_d      = ST_WR_BURST;
          last_grant_d = GNT_WRITE;
        end else if (rd_elig) begin
          state_d      = ST_RD_CMD;
          last_grant_d = GNT_READ;
        end
      end
      ST_WR_BURST: begin
        // wr_beats_q == 0 inside a burst means no beat has been accepted yet;
        // it returns to 0 exactly when the last beat goes out.
        if (wr_accept) begin
          if (wr_beats_q == 8'd0) begin
            wr_beats_d = wr_bc_eff - 8'd1;
            if (wr_bc_eff == 8'd1) begin
              state_d = ST_IDLE;
            end
          end else begin
            wr_beats_d = wr_beats_q - 8'd1;
            if (wr_beats_q == 8'd1) begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_RD_CMD: begin
        if (!rd_s.read || rd_accept) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rd_next_wide = {1'b0, rd_outstanding_q}
                 + (rd_accept ? {2'b00, rd_bc_eff} : 10'd0)
                 - ((m.readdatavalid && !rdv_stray) ? 10'd1 : 10'd0);
    rd_outstanding_d = rd_next_wide[8:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      last_grant_q     <= GNT_READ;
      wr_beats_q       <= 8'd0;
      rd_outstanding_q <= 9'd0;
      rdv_err_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      wr_beats_q       <= wr_beats_d;
      rd_outstanding_q <= rd_outstanding_d;
      rdv_err_q        <= rdv_err_d;
    end
  end

  assign rd_outstanding = rd_outstanding_q;
  assign rdv_err        = rdv_err_q;
  assign busy           = (state_q != ST_IDLE) || (rd_outstanding_q != 9'd0);

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// tb/tb_sdram_rw_arbiter.sv - directed self-checking bench for sdram_rw_arbiter
module tb_sdram_rw_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] rd_outstanding;
  logic       busy;
  logic       rdv_err;
  logic [10:0] wp;
  int         beat;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  sdram_ifc w_if ();
  sdram_ifc r_if ();
  sdram_ifc m_if ();

  sdram_rw_arbiter #(
    .WIDTH_ADDR   (29),
    .WIDTH_DATA   (64),
    .WIDTH_BE     (8),
    .MAX_RD_BEATS (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_s           (w_if),
    .rd_s           (r_if),
    .m              (m_if),
    .rd_outstanding (rd_outstanding),
    .busy           (busy),
    .rdv_err        (rdv_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    // Signals of the shared bundle that these ports never use.
    w_if.read          = 1'b0;
    w_if.readdata      = '0;
    w_if.readdatavalid = 1'b0;
    r_if.writedata     = '0;
    r_if.byteenable    = '0;
    r_if.write         = 1'b0;

    reset              = 1'b1;
    w_if.address       = '0;
    w_if.burstcount    = '0;
    w_if.writedata     = '0;
    w_if.byteenable    = 8'hFF;
    w_if.write         = 1'b0;
    r_if.address       = '0;
    r_if.burstcount    = '0;
    r_if.read          = 1'b0;
    m_if.waitrequest   = 1'b0;
    m_if.readdata      = '0;
    m_if.readdatavalid = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    settle();

    // Reset state
    check("rst_m_write", m_if.write, 0);
    check("rst_m_read", m_if.read, 0);
    check("rst_m_addr", m_if.address, 0);
    check("rst_wwait", w_if.waitrequest, 1);
    check("rst_rwait", r_if.waitrequest, 1);
    check("rst_rdv", r_if.readdatavalid, 0);
    check("rst_outst", rd_outstanding, 0);
    check("rst_busy", busy, 0);
    check("rst_err", rdv_err, 0);

    // Single write burst of 4
    w_if.address    = 29'h100;
    w_if.burstcount = 8'd4;
    w_if.write      = 1'b1;
    w_if.writedata  = 64'hA0;
    settle();
    check("t1_grant_nofwd", m_if.write, 0);
    check("t1_grant_wwait", w_if.waitrequest, 1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      w_if.writedata = 64'hA0 + 64'(i);
      settle();
      check("t1_beat_write", m_if.write, 1);
      check("t1_beat_data", m_if.writedata, 64'hA0 + 64'(i));
      check("t1_beat_addr", m_if.address, 29'h100);
      check("t1_beat_wwait", w_if.waitrequest, 0);
      cyc();
    end
    w_if.write = 1'b0;
    settle();
    check("t1_end_write", m_if.write, 0);
    check("t1_end_wwait", w_if.waitrequest, 1);
    check("t1_end_busy", busy, 0);

    // Contention from reset: write first, then round-robin hands read the next tie
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    w_if.address    = 29'h180;
    w_if.burstcount = 8'd2;
    w_if.write      = 1'b1;
    r_if.address    = 29'h200;
    r_if.burstcount = 8'd2;
    r_if.read       = 1'b1;
    settle();
    check("t2_idle_write", m_if.write, 0);
    check("t2_idle_read", m_if.read, 0);
    cyc();
    for (int i = 0; i < 2; i++) begin
      w_if.writedata = 64'hC0 + 64'(i);
      settle();
      check("t2_w1_write", m_if.write, 1);
      check("t2_w1_read", m_if.read, 0);
      check("t2_w1_rwait", r_if.waitrequest, 1);
      check("t2_w1_data", m_if.writedata, 64'hC0 + 64'(i));
      cyc();
    end
    settle();
    check("t2_idle2_write", m_if.write, 0);
    cyc();
    check("t2_rd_read", m_if.read, 1);
    check("t2_rd_write", m_if.write, 0);
    check("t2_rd_addr", m_if.address, 29'h200);
    check("t2_rd_bc", m_if.burstcount, 2);
    check("t2_rd_rwait", r_if.waitrequest, 0);
    check("t2_rd_wwait", w_if.waitrequest, 1);
    cyc();
    r_if.read = 1'b0;
    settle();
    check("t2_outst2", rd_outstanding, 2);
    check("t2_idle3_read", m_if.read, 0);
    cyc();
    for (int i = 0; i < 2; i++) begin
      w_if.writedata = 64'hD0 + 64'(i);
      settle();
      check("t2_w2_write", m_if.write, 1);
      check("t2_w2_data", m_if.writedata, 64'hD0 + 64'(i));
      cyc();
    end
    w_if.write = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_if.readdatavalid = 1'b1;
      m_if.readdata      = 64'hE0 + 64'(i);
      settle();
      check("t2_ret_valid", r_if.readdatavalid, 1);
      check("t2_ret_data", r_if.readdata, 64'hE0 + 64'(i));
      cyc();
    end
    m_if.readdatavalid = 1'b0;
    settle();
    check("t2_outst0", rd_outstanding, 0);

    // Backpressure in the middle of an 8-beat write
    w_if.address    = 29'h400;
    w_if.burstcount = 8'd8;
    w_if.write      = 1'b1;
    cyc();
    wp   = 11'h038;
    beat = 0;
    for (int i = 0; i < 11; i++) begin
      m_if.waitrequest = wp[i];
      w_if.writedata   = 64'hB0 + 64'(beat);
      settle();
      check("t3_wwait", w_if.waitrequest, wp[i]);
      check("t3_write", m_if.write, 1);
      check("t3_data", m_if.writedata, 64'hB0 + 64'(beat));
      if (!wp[i]) beat++;
      cyc();
    end
    m_if.waitrequest = 1'b0;
    settle();
    check("t3_done_write", m_if.write, 0);
    check("t3_done_wwait", w_if.waitrequest, 1);
    w_if.write = 1'b0;

    // Read cap at 16 beats
    r_if.address    = 29'h300;
    r_if.burstcount = 8'd8;
    r_if.read       = 1'b1;
    cyc();
    cyc();
    cyc();
    cyc();
    settle();
    check("t4_outst16", rd_outstanding, 16);
    check("t4_block_rwait", r_if.waitrequest, 1);
    check("t4_block_read", m_if.read, 0);
    cyc();
    cyc();
    check("t4_still_block", m_if.read, 0);
    check("t4_busy", busy, 1);
    m_if.readdatavalid = 1'b1;
    cyc();
    m_if.readdatavalid = 1'b0;
    settle();
    check("t4_outst15", rd_outstanding, 15);
    cyc();
    check("t4_15_block", m_if.read, 0);
    m_if.readdatavalid = 1'b1;
    repeat (7) cyc();
    m_if.readdatavalid = 1'b0;
    settle();
    check("t4_outst8", rd_outstanding, 8);
    check("t4_8_idle", m_if.read, 0);
    cyc();
    check("t4_issue_read", m_if.read, 1);
    check("t4_issue_rwait", r_if.waitrequest, 0);
    check("t4_issue_bc", m_if.burstcount, 8);
    cyc();
    r_if.read = 1'b0;
    settle();
    check("t4_outst16b", rd_outstanding, 16);
    m_if.readdatavalid = 1'b1;
    repeat (16) cyc();
    m_if.readdatavalid = 1'b0;
    settle();
    check("t4_drained", rd_outstanding, 0);

    // Command accept coinciding with a returned beat, then a stray beat
    r_if.burstcount = 8'd5;
    r_if.read       = 1'b1;
    cyc();
    cyc();
    r_if.burstcount = 8'd4;
    settle();
    check("t5_outst5", rd_outstanding, 5);
    cyc();
    m_if.readdatavalid = 1'b1;
    settle();
    check("t5_rdcmd", m_if.read, 1);
    cyc();
    r_if.read          = 1'b0;
    m_if.readdatavalid = 1'b0;
    settle();
    check("t5_outst8", rd_outstanding, 8);
    m_if.readdatavalid = 1'b1;
    repeat (8) cyc();
    m_if.readdatavalid = 1'b0;
    settle();
    check("t5_outst0", rd_outstanding, 0);
    check("t5_err_clear", rdv_err, 0);
    m_if.readdatavalid = 1'b1;
    cyc();
    m_if.readdatavalid = 1'b0;
    settle();
    check("t5_err_set", rdv_err, 1);
    check("t5_stray_outst", rd_outstanding, 0);
    repeat (3) cyc();
    check("t5_err_held", rdv_err, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    settle();
    check("t5_err_reset", rdv_err, 0);

    // Burstcount 0 behaves as a single beat
    w_if.burstcount = 8'd0;
    w_if.write      = 1'b1;
    cyc();
    check("t6_bc0_write", m_if.write, 1);
    cyc();
    check("t6_bc0_done", m_if.write, 0);
    w_if.write = 1'b0;
    cyc();

    // Reset two beats into a 4-beat write
    w_if.address    = 29'h500;
    w_if.burstcount = 8'd4;
    w_if.write      = 1'b1;
    cyc();
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    settle();
    check("t7_rst_write", m_if.write, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_wwait", w_if.waitrequest, 1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      w_if.writedata = 64'hF0 + 64'(i);
      settle();
      check("t7_beat_write", m_if.write, 1);
      check("t7_beat_data", m_if.writedata, 64'hF0 + 64'(i));
      check("t7_beat_wwait", w_if.waitrequest, 0);
      cyc();
    end
    settle();
    check("t7_end_write", m_if.write, 0);
    w_if.write = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
